// File: rtl/sclk_burst_gen_if.sv
// Control and status bundle for the serial-clock burst generator.
// The master side issues bursts and watches strobes; the slave side is the generator.
interface sclk_burst_gen_if #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 8
);
    logic [WIDTH-1:0] halfperiod;
    logic             cpol;
    logic [CNTW-1:0]  ncycles;
    logic             free_run;
    logic             start;
    logic             stop;
    logic             clkout;
    logic             lead_stb;
    logic             trail_stb;
    logic             busy;
    logic             done;

    modport master (
        output halfperiod, cpol, ncycles, free_run, start, stop,
        input  clkout, lead_stb, trail_stb, busy, done
    );

    modport slave (
        input  halfperiod, cpol, ncycles, free_run, start, stop,
        output clkout, lead_stb, trail_stb, busy, done
    );
endinterface

// File: rtl/sclk_burst_gen.sv
// Serial clock burst generator: half period of hp+1 clkin cycles, registered per-edge strobes.
// Start is taken only in IDLE; every output is a flop, so edges and strobes appear one cycle after the deciding edge.
module sclk_burst_gen #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 8
) (
    input  logic           clkin,
    input  logic           rst,
    sclk_burst_gen_if.slave bus
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_hp, w_hp_nxt;
    logic [WIDTH-1:0] r_tick, w_tick_nxt;
    logic             r_pol, w_pol_nxt;
    logic [CNTW-1:0]  r_n, w_n_nxt;
    logic             r_fr, w_fr_nxt;
    logic [CNTW:0]    r_edge, w_edge_nxt, w_edge_inc;
    logic             r_stop_pend, w_stop_pend_nxt;
    logic             r_clkout, w_clkout_nxt;
    logic             r_lead, w_lead_nxt;
    logic             r_trail, w_trail_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    assign w_edge_inc = r_edge + {{CNTW{1'b0}}, 1'b1};

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hp        <= '0;
            r_tick      <= '0;
            r_pol       <= 1'b0;
            r_n         <= '0;
            r_fr        <= 1'b0;
            r_edge      <= '0;
            r_stop_pend <= 1'b0;
            r_clkout    <= 1'b0;
            r_lead      <= 1'b0;
            r_trail     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hp        <= w_hp_nxt;
            r_tick      <= w_tick_nxt;
            r_pol       <= w_pol_nxt;
            r_n         <= w_n_nxt;
            r_fr        <= w_fr_nxt;
            r_edge      <= w_edge_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            r_clkout    <= w_clkout_nxt;
            r_lead      <= w_lead_nxt;
            r_trail     <= w_trail_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_hp_nxt        = r_hp;
        w_tick_nxt      = r_tick;
        w_pol_nxt       = r_pol;
        w_n_nxt         = r_n;
        w_fr_nxt        = r_fr;
        w_edge_nxt      = r_edge;
        w_stop_pend_nxt = r_stop_pend;
        w_clkout_nxt    = r_clkout;
        w_lead_nxt      = 1'b0;
        w_trail_nxt     = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clkout_nxt = bus.cpol;
                if (bus.start) begin
                    if (bus.free_run || (bus.ncycles != '0)) begin
                        w_state_nxt     = S_RUN;
                        w_hp_nxt        = bus.halfperiod;
                        w_pol_nxt       = bus.cpol;
                        w_n_nxt         = bus.ncycles;
                        w_fr_nxt        = bus.free_run;
                        w_tick_nxt      = '0;
                        w_edge_nxt      = '0;
                        w_stop_pend_nxt = 1'b0;
                        w_busy_nxt      = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    w_stop_pend_nxt = 1'b1;
                end
                if (r_tick == r_hp) begin
                    w_tick_nxt   = '0;
                    w_edge_nxt   = w_edge_inc;
                    w_clkout_nxt = ~r_clkout;
                    if (w_edge_inc[0]) begin
                        w_lead_nxt = 1'b1;
                    end else begin
                        w_trail_nxt = 1'b1;
                        // A trailing edge is the only place a burst may end, so clkout always lands idle.
                        if ((!r_fr && (w_edge_inc == {r_n, 1'b0})) || r_stop_pend || bus.stop) begin
                            w_state_nxt  = S_IDLE;
                            w_busy_nxt   = 1'b0;
                            w_done_nxt   = 1'b1;
                            w_clkout_nxt = r_pol;
                        end
                    end
                end else begin
                    w_tick_nxt = r_tick + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.clkout    = r_clkout;
    assign bus.lead_stb  = r_lead;
    assign bus.trail_stb = r_trail;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_sclk_burst_gen.sv
// Bench for sclk_burst_gen: expected edge/done events are derived from burst timing arithmetic and
// queued at start time; an independent monitor pops and compares each strobe or done the DUT shows.
module tb_sclk_burst_gen;
    localparam int W = 16;
    localparam int C = 8;

    typedef struct {
        int cyc;
        bit lead;
        bit trail;
        bit done;
        bit clk;
        bit busy;
    } ev_t;

    logic clkin = 1'b0;
    logic rst   = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    ev_t  sb_q[$];

    sclk_burst_gen_if #(.WIDTH(W), .CNTW(C)) bus ();

    sclk_burst_gen #(.WIDTH(W), .CNTW(C)) dut (
        .clkin (clkin),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    // Monitor: every strobe or done must match the head of the expected-event queue.
    always @(negedge clkin) begin
        if (bus.lead_stb || bus.trail_stb || bus.done) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d lead=%0b trail=%0b done=%0b (none expected)",
                         cyc, bus.lead_stb, bus.trail_stb, bus.done);
            end else begin
                ev_t e;
                e = sb_q.pop_front();
                if (cyc != e.cyc || bus.lead_stb != e.lead || bus.trail_stb != e.trail ||
                    bus.done != e.done || bus.clkout != e.clk || bus.busy != e.busy) begin
                    failures++;
                    $display("FAIL event got cyc=%0d l=%0b t=%0b d=%0b clk=%0b busy=%0b exp cyc=%0d l=%0b t=%0b d=%0b clk=%0b busy=%0b",
                             cyc, bus.lead_stb, bus.trail_stb, bus.done, bus.clkout, bus.busy,
                             e.cyc, e.lead, e.trail, e.done, e.clk, e.busy);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Expected events from the timing rules: lead k at E0+(2k-1)(hp+1), trail k at E0+2k(hp+1).
    task automatic model(input int e0, input int hp, input bit cp, input int n, input bit fr, input int stop_d);
        int per;
        int k;
        per = 2 * (hp + 1);
        if (!fr && n == 0) begin
            sb_q.push_back('{cyc: e0, lead: 0, trail: 0, done: 1, clk: cp, busy: 0});
        end else begin
            k = fr ? (stop_d + per - 1) / per : n;
            if (k < 1) k = 1;
            for (int i = 1; i <= k; i++) begin
                sb_q.push_back('{cyc: e0 + (2*i-1)*(hp+1), lead: 1, trail: 0, done: 0, clk: ~cp, busy: 1});
                sb_q.push_back('{cyc: e0 + 2*i*(hp+1), lead: 0, trail: 1, done: (i == k), clk: cp, busy: (i != k)});
            end
        end
    endtask

    task automatic run_burst(input int hp, input bit cp, input int n, input bit fr, input int stop_d,
                             input int gap, input bit chg, input bit collide, input int rst_at);
        int  e0;
        int  budget;
        bit  seen;
        bus.halfperiod = W'(hp);
        bus.cpol       = cp;
        bus.ncycles    = C'(n);
        bus.free_run   = fr;
        repeat (gap) @(negedge clkin);
        bus.start = 1'b1;
        bus.stop  = collide;
        e0 = cyc + 1;
        model(e0, hp, cp, n, fr, stop_d);
        @(negedge clkin);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        if (chg) begin
            bus.halfperiod = W'($urandom_range(0, 7));
            bus.cpol       = ~cp;
            bus.ncycles    = C'($urandom_range(0, 255));
            bus.free_run   = ~fr;
        end
        seen   = bus.done;
        budget = 2 * (hp + 1) * (n + 2) + stop_d + 20;
        for (int c = 0; c < budget && !seen; c++) begin
            bus.stop = (fr && (cyc + 1 == e0 + stop_d));
            if (rst_at > 0 && (cyc + 1 == e0 + rst_at)) rst = 1'b1;
            @(negedge clkin);
            if (rst) begin
                chk("rst_mid_clkout", bus.clkout, 0);
                chk("rst_mid_busy", bus.busy, 0);
                chk("rst_mid_strobes", {bus.lead_stb, bus.trail_stb, bus.done}, 0);
                sb_q.delete();
                rst  = 1'b0;
                seen = 1'b1;
                repeat (3) @(negedge clkin);
            end else if (bus.done) begin
                seen = 1'b1;
            end
        end
        bus.stop = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL burst_timeout hp=%0d n=%0d fr=%0b no done within %0d cycles", hp, n, fr, budget);
            sb_q.delete();
        end
    endtask

    initial begin
        bus.halfperiod = '0;
        bus.cpol       = 1'b1;
        bus.ncycles    = '0;
        bus.free_run   = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        rst            = 1'b1;
        repeat (3) @(negedge clkin);
        chk("reset_clkout", bus.clkout, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        rst = 1'b0;
        @(negedge clkin);
        chk("idle_cpol_follow", bus.clkout, 1);
        chk("idle_no_strobes", {bus.lead_stb, bus.trail_stb}, 0);
        bus.cpol = 1'b0;
        repeat (2) @(negedge clkin);
        chk("idle_cpol_low", bus.clkout, 0);

        run_burst(3, 0, 2,   0, 0, 2, 0, 0, 0);   // basic
        run_burst(0, 1, 255, 0, 0, 2, 0, 0, 0);   // hp=0, cpol=1, longest burst
        run_burst(5, 0, 0,   1, 8, 2, 0, 0, 0);   // free-run with stop in first active half
        chk("fr_idle_level", bus.clkout, 0);
        run_burst(3, 0, 2,   0, 0, 2, 1, 0, 0);   // inputs wiggle mid-burst
        run_burst(1, 1, 2,   0, 0, 2, 0, 0, 0);   // next burst with the new values
        run_burst(2, 0, 0,   0, 0, 2, 0, 0, 0);   // zero-length start
        chk("zero_len_busy", bus.busy, 0);
        run_burst(2, 1, 3,   0, 0, 2, 0, 1, 0);   // start and stop together
        run_burst(3, 0, 4,   0, 0, 2, 0, 0, 6);   // reset mid-burst
        repeat (4) @(negedge clkin);
        run_burst(0, 0, 1,   0, 0, 1, 0, 0, 0);
        run_burst(1, 1, 2,   0, 0, 0, 0, 0, 0);   // back-to-back, one idle cycle

        for (int i = 0; i < 25; i++) begin
            bit fr;
            fr = ($urandom_range(0, 3) == 0);
            run_burst($urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 5), fr,
                      fr ? $urandom_range(1, 40) : 0, $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        repeat (5) @(negedge clkin);
        chk("queue_drained", sb_q.size(), 0);
        chk("final_busy", bus.busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sclk_burst_gen.md
# sclk_burst_gen

Parametrised serial-clock generator for the Bus Pirate Ultra protocol engines (SPI, raw-wire, 2/3-wire). Divides `clkin` by a programmable half-period, adds idle polarity (CPOL), burst-length counting, free-run mode with a clean stop, and per-edge strobes so shift registers can sample and launch data without extra edge detectors. Parameters are latched at start, so a period change never produces a runt pulse.

## Interface

- `WIDTH`, 16: width of `halfperiod`.
- `CNTW`, 8: width of `ncycles`.

- `clkin` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `halfperiod` in WIDTH: half period is `halfperiod`+1 `clkin` cycles.
- `cpol` in 1: idle level of `clkout`.
- `ncycles` in CNTW: number of full `clkout` periods per burst.
- `free_run` in 1: if 1 at start, ignore `ncycles` and run until `stop`.
- `start` in 1: single-cycle request.
- `stop` in 1: request to terminate at the next trailing edge.
- `clkout` out 1: generated serial clock.
- `lead_stb` out 1: 1-cycle pulse, coincident with idle→active transition of `clkout`.
- `trail_stb` out 1: 1-cycle pulse, coincident with active→idle transition.
- `busy` out 1: burst in progress.
- `done` out 1: 1-cycle pulse at burst end.

## Operation

- States: IDLE, RUN.
- Reset values: state IDLE, `clkout`=0, `busy`=0, `done`=0, `lead_stb`=0, `trail_stb`=0. All internal counters are 0 and `stop_pend` is 0.
- **IDLE:**
  - `clkout` <= `cpol` every cycle, so it follows with one-cycle latency.
  - `stop` is ignored.
- **IDLE → RUN:** `start`=1 and (`free_run`=1 or `ncycles`≠0).
  - Latch `hp`=`halfperiod`, `pol`=`cpol`, `n`=`ncycles` and `fr`=`free_run`.
  - Clear the tick counter and the edge counter (CNTW+1 bits).
  - Clear `stop_pend`.
  - Set `busy`=1.
- **Zero-length start:** `start`=1, `free_run`=0, `ncycles`=0. State stays IDLE, `busy` stays 0, `done` pulses next cycle, and `clkout` does not move.
- **RUN:**
  - The tick counter increments each cycle.
  - When tick==`hp`: clear tick, toggle `clkout`, and increment the edge counter.
  - An odd edge (1st, 3rd, …) is leading: assert `lead_stb` with the toggle.
  - An even edge is trailing: assert `trail_stb` with the toggle.
  - `start` is ignored.
  - Input changes to `halfperiod`, `cpol`, `ncycles` and `free_run` are ignored until the next start.
  - `stop`=1 sets `stop_pend`.
- **Termination:** at a trailing edge, if (`fr`=0 and edge count == 2·`n`) or `stop_pend` or `stop` is 1 that cycle:
  - Go to IDLE with `busy`=0.
  - Pulse `done` on the same edge as the final `trail_stb`.
  - `clkout` lands at `pol`, so it always ends at idle level and never stops mid-period.
- **Start/stop collision:** `start` and `stop` in the same IDLE cycle. The start is accepted and the stop is discarded.
- **Reset mid-burst:** all outputs return to reset values on the next edge. No `done` and no strobe is emitted.
- **Arithmetic:**
  - The tick counter is WIDTH bits.
  - The edge counter is CNTW+1 bits; compare against {`n`,1'b0}.
  - In free-run the edge counter wraps freely and its value is ignored.

## Timing

- Start is sampled at edge E0, so `busy`=1 after E0.
- Leading edge k (k=1..n): E0 + (2k−1)(`hp`+1) cycles.
- Trailing edge k: E0 + 2k(`hp`+1) cycles.
- `done` and `busy`↓ coincide with the final trailing edge: burst length 2·n·(`hp`+1) cycles after E0.
- A new `start` is accepted the cycle after `done`, giving back-to-back bursts with one idle cycle minimum.
- `hp`=0: `clkout` = `clkin`/2; strobes fire on alternate cycles.
- Strobes and `clkout` are registered; all outputs are glitch-free flops.

## Test plan

- **Reset and idle polarity:**
  - Assert `rst` with `cpol`=1.
  - Expect `clkout`=0, `busy`=0.
  - Release `rst`; expect `clkout`=1 one cycle later, with no strobes.
- **Basic burst:**
  - Stimulus: `hp`=3, `cpol`=0, `ncycles`=2, start at E0.
  - Expect leading edges at E0+4 and E0+12, trailing edges at E0+8 and E0+16.
  - At E0+16: `done`=1 for one cycle and `busy`↓.
  - Exactly 2 `lead_stb` and 2 `trail_stb`.
- **CPOL=1, hp=0, ncycles=255:**
  - Expect `clkout` idles high and first transition is high→low at E0+1.
  - Expect 510 toggles, ending high with `done`.
- **Free-run stop:**
  - Stimulus: `hp`=5, `free_run`=1; pulse `stop` at E0+8, during the first active half.
  - Expect termination at trailing edge E0+12 with `done`, and `clkout` back at idle.
- **Parameter change mid-burst:**
  - Stimulus: change `halfperiod` 3→1 and toggle `cpol` during RUN.
  - Expect the edge spacing stays 4 cycles and the burst completes unchanged.
  - Expect the next burst uses the new values.
- **Corner cases:**
  - `ncycles`=0 start: expect `done` at E0 and `busy` never set.
  - `start`+`stop` together in IDLE: expect a normal full burst.
  - `rst` at E0+6 of a burst: expect outputs cleared and no `done`.
